// File: rtl/icache_param.sv
// Direct-mapped instruction cache with a zero-cycle hit path and an AXI4 INCR
// line refill. A bad burst leaves the cache in a terminal ERROR state until reset.
`timescale 1ns/1ps

module icache_param #(
   parameter int INDEX_BITS = 10,
   parameter int WORDS_LOG2 = 4
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        mem_start_valid,
   input  logic [31:0] mem_start_input,
   input  logic        req_valid,
   input  logic [31:0] req_addr,
   input  logic        flush,
   output logic        hit,
   output logic [31:0] rdata,
   output logic        busy,
   output logic        error,
   output logic        m_arvalid,
   input  logic        m_arready,
   output logic [31:0] m_araddr,
   output logic [7:0]  m_arlen,
   output logic [2:0]  m_arsize,
   output logic [1:0]  m_arburst,
   input  logic        m_rvalid,
   output logic        m_rready,
   input  logic [31:0] m_rdata,
   input  logic [1:0]  m_rresp,
   input  logic        m_rlast
);

   // state    | meaning
   // ---------+--------------------------------------------------------
   // CLEAR    | invalidating one line per cycle, index 0 upward
   // IDLE     | lookups served; a miss launches a refill
   // MISS_AR  | read address presented, waiting for m_arready
   // MISS_R   | collecting burst beats into the line buffer
   // FILL     | writing the completed line into the arrays
   // ERROR    | refill failed; parked until reset

   localparam int TAG_BITS = 32 - INDEX_BITS - WORDS_LOG2 - 2;
   localparam int LINES    = 1 << INDEX_BITS;
   localparam int WORDS    = 1 << WORDS_LOG2;
   localparam int LA_W     = TAG_BITS + INDEX_BITS;
   localparam logic [INDEX_BITS-1:0] LAST_IDX  = '1;
   localparam logic [WORDS_LOG2-1:0] LAST_BEAT = '1;

   typedef enum logic [2:0] {
      S_CLEAR, S_IDLE, S_MISS_AR, S_MISS_R, S_FILL, S_ERROR
   } state_t;

   state_t                      state;
   logic [31:0]                 base;
   logic [31:0]                 pa;
   logic [TAG_BITS-1:0]         pa_tag;
   logic [INDEX_BITS-1:0]       pa_idx;
   logic [WORDS_LOG2-1:0]       pa_word;
   logic [LA_W-1:0]             line_addr;
   logic [INDEX_BITS-1:0]       clr_cnt;
   logic [WORDS_LOG2-1:0]       beat_cnt;
   logic                        bad;
   logic                        flush_pend;
   logic                        lookup;
   logic                        beat_err;
   logic                        beat_end;
   logic                        bad_next;
   logic                        unused_byte_bits;

   logic [LINES-1:0]            valid_q;
   logic [TAG_BITS-1:0]         tag_mem  [LINES];
   logic [WORDS-1:0][31:0]      data_mem [LINES];
   logic [WORDS-1:0][31:0]      line_buf;

   assign pa      = base + req_addr;
   assign pa_tag  = pa[31 -: TAG_BITS];
   assign pa_idx  = pa[WORDS_LOG2+2 +: INDEX_BITS];
   assign pa_word = pa[2 +: WORDS_LOG2];
   assign unused_byte_bits = ^pa[1:0];

   assign lookup = valid_q[pa_idx] && (tag_mem[pa_idx] == pa_tag);
   // A flush in the same cycle suppresses the hit so the lookup never races the clear.
   assign hit    = (state == S_IDLE) && req_valid && !flush && lookup;
   assign rdata  = hit ? data_mem[pa_idx][pa_word] : 32'h0000_003F;
   assign busy   = (state != S_IDLE);

   assign m_araddr  = {line_addr, {(WORDS_LOG2+2){1'b0}}};
   assign m_arlen   = 8'(WORDS - 1);
   assign m_arsize  = 3'b010;
   assign m_arburst = 2'b01;
   assign m_rready  = (state == S_MISS_R);

   assign beat_err = (m_rresp != 2'b00) || (m_rlast != (beat_cnt == LAST_BEAT));
   assign beat_end = m_rlast || (beat_cnt == LAST_BEAT);
   assign bad_next = bad || beat_err;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state      <= S_CLEAR;
         clr_cnt    <= '0;
         base       <= '0;
         error      <= 1'b0;
         m_arvalid  <= 1'b0;
         flush_pend <= 1'b0;
         bad        <= 1'b0;
         beat_cnt   <= '0;
         line_addr  <= '0;
      end else begin
         if (mem_start_valid) base <= mem_start_input;
         unique case (state)
            S_CLEAR: begin
               clr_cnt    <= clr_cnt + 1'b1;
               flush_pend <= 1'b0;
               if (clr_cnt == LAST_IDX) state <= S_IDLE;
            end
            S_IDLE: begin
               if (flush) begin
                  clr_cnt <= '0;
                  state   <= S_CLEAR;
               end else if (req_valid && !lookup) begin
                  line_addr <= pa[31:WORDS_LOG2+2];
                  m_arvalid <= 1'b1;
                  state     <= S_MISS_AR;
               end
            end
            S_MISS_AR: begin
               if (flush) flush_pend <= 1'b1;
               if (m_arready) begin
                  m_arvalid <= 1'b0;
                  beat_cnt  <= '0;
                  bad       <= 1'b0;
                  state     <= S_MISS_R;
               end
            end
            S_MISS_R: begin
               if (flush) flush_pend <= 1'b1;
               if (m_rvalid) begin
                  beat_cnt <= beat_cnt + 1'b1;
                  bad      <= bad_next;
                  if (beat_end) begin
                     if (bad_next) begin
                        error <= 1'b1;
                        state <= S_ERROR;
                     end else begin
                        state <= S_FILL;
                     end
                  end
               end
            end
            S_FILL: begin
               clr_cnt    <= '0;
               flush_pend <= 1'b0;
               state      <= (flush_pend || flush) ? S_CLEAR : S_IDLE;
            end
            S_ERROR: state <= S_ERROR;
            default: state <= S_CLEAR;
         endcase
      end
   end

   // Arrays carry no reset; CLEAR invalidates every line before IDLE is reachable.
   always_ff @(posedge clk) begin
      if (state == S_MISS_R && m_rvalid) line_buf[beat_cnt] <= m_rdata;
      if (state == S_CLEAR) valid_q[clr_cnt] <= 1'b0;
      if (resetn && state == S_FILL) begin
         valid_q[line_addr[INDEX_BITS-1:0]]  <= 1'b1;
         tag_mem[line_addr[INDEX_BITS-1:0]]  <= line_addr[LA_W-1:INDEX_BITS];
         data_mem[line_addr[INDEX_BITS-1:0]] <= line_buf;
      end
   end

endmodule

// File: tb/tb_icache_param.sv
// Bench for icache_param: directed and randomized fetches scored against a
// simple line-presence model and an identity memory (word at address a is a).
`timescale 1ns/1ps

module tb_icache_param;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        resetn, mem_start_valid, req_valid, flush;
   logic [31:0] mem_start_input, req_addr;
   logic        hit, busy, error, m_arvalid, m_rready;
   logic [31:0] rdata, m_araddr;
   logic [7:0]  m_arlen;
   logic [2:0]  m_arsize;
   logic [1:0]  m_arburst;
   logic        m_arready, m_rvalid, m_rlast;
   logic [31:0] m_rdata;
   logic [1:0]  m_rresp;

   logic        s_req_valid;
   logic [31:0] s_req_addr;
   logic        s_hit, s_busy, s_error, s_m_arvalid, s_m_rready;
   logic [31:0] s_rdata, s_unused_araddr;
   logic [7:0]  s_m_arlen;
   logic [2:0]  s_m_arsize;
   logic [1:0]  s_m_arburst;

   icache_param dut (
      .clk(clk), .resetn(resetn),
      .mem_start_valid(mem_start_valid), .mem_start_input(mem_start_input),
      .req_valid(req_valid), .req_addr(req_addr), .flush(flush),
      .hit(hit), .rdata(rdata), .busy(busy), .error(error),
      .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
      .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
      .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata),
      .m_rresp(m_rresp), .m_rlast(m_rlast)
   );

   icache_param #(.INDEX_BITS(2), .WORDS_LOG2(1)) dut_small (
      .clk(clk), .resetn(resetn),
      .mem_start_valid(1'b0), .mem_start_input(32'h0),
      .req_valid(s_req_valid), .req_addr(s_req_addr), .flush(1'b0),
      .hit(s_hit), .rdata(s_rdata), .busy(s_busy), .error(s_error),
      .m_arvalid(s_m_arvalid), .m_arready(1'b0), .m_araddr(s_unused_araddr),
      .m_arlen(s_m_arlen), .m_arsize(s_m_arsize), .m_arburst(s_m_arburst),
      .m_rvalid(1'b0), .m_rready(s_m_rready), .m_rdata(32'h0),
      .m_rresp(2'b00), .m_rlast(1'b0)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: which line (by tag) each index holds, plus the current base.
   bit          mv [1024];
   logic [31:0] mt [1024];
   logic [31:0] model_base;

   function automatic int idx_of(input logic [31:0] pa);
      return int'((pa >> 6) % 1024);
   endfunction

   function automatic bit model_hit(input logic [31:0] pa);
      return mv[idx_of(pa)] && (mt[idx_of(pa)] == (pa >> 16));
   endfunction

   function automatic void model_fill(input logic [31:0] pa);
      mv[idx_of(pa)] = 1'b1;
      mt[idx_of(pa)] = pa >> 16;
   endfunction

   function automatic void model_clear();
      foreach (mv[i]) mv[i] = 1'b0;
   endfunction

   task automatic idle_inputs();
      mem_start_valid = 0; mem_start_input = 0; req_valid = 0; req_addr = 0; flush = 0;
      m_arready = 0; m_rvalid = 0; m_rdata = 0; m_rresp = 0; m_rlast = 0;
      s_req_valid = 0; s_req_addr = 0;
   endtask

   task automatic do_reset(output int n_big, output int n_small);
      idle_inputs();
      resetn = 0;
      repeat (2) @(negedge clk);
      resetn = 1;
      model_clear();
      model_base = 0;
      n_big = -1; n_small = -1;
      for (int k = 1; k <= 1200; k++) begin
         @(negedge clk);
         if (n_small < 0 && s_busy === 1'b0) n_small = k;
         if (busy === 1'b0) begin n_big = k; break; end
      end
   endtask

   task automatic set_base(input logic [31:0] b);
      mem_start_input = b; mem_start_valid = 1;
      @(negedge clk);
      mem_start_valid = 0;
      model_base = b;
   endtask

   // Acts as the memory slave for one refill; called while the cache sits in MISS_AR.
   task automatic serve_refill(input int ar_wait, input int err_beat, input int last_beat,
                               input int flush_beat, input logic [31:0] exp_araddr);
      int t = 0;
      while (m_arvalid !== 1'b1 && t < 20) begin @(negedge clk); t++; end
      checks++;
      if (m_arvalid !== 1'b1) begin
         errors++;
         $display("FAIL ar_timeout m_arvalid=%b expected 1", m_arvalid);
         return;
      end
      checks++;
      if (m_araddr !== exp_araddr || m_arlen !== 8'd15) begin
         errors++;
         $display("FAIL araddr got %h/%0d expected %h/15", m_araddr, m_arlen, exp_araddr);
      end
      for (int w = 0; w < ar_wait; w++) begin
         m_arready = 0;
         @(negedge clk);
         checks++;
         if (m_arvalid !== 1'b1 || m_araddr !== exp_araddr) begin
            errors++;
            $display("FAIL ar_hold cycle %0d got %b/%h expected 1/%h", w, m_arvalid, m_araddr, exp_araddr);
         end
      end
      m_arready = 1;
      @(negedge clk);
      m_arready = 0;
      checks++;
      if (m_arvalid !== 1'b0 || m_rready !== 1'b1) begin
         errors++;
         $display("FAIL ar_done arvalid=%b rready=%b expected 0/1", m_arvalid, m_rready);
      end
      for (int b = 0; b < 16; b++) begin
         m_rvalid = 1;
         m_rdata  = exp_araddr + 32'(4 * b);
         m_rresp  = (b == err_beat) ? 2'b10 : 2'b00;
         m_rlast  = (b == last_beat);
         flush    = (b == flush_beat);
         @(negedge clk);
         if (b == last_beat) break;
      end
      m_rvalid = 0; m_rlast = 0; m_rresp = 0; flush = 0;
   endtask

   task automatic test_reset();
      int nb, ns;
      do_reset(nb, ns);
      checks++;
      if (nb !== 1024) begin errors++; $display("FAIL reset_busy_big got %0d expected 1024", nb); end
      checks++;
      if (ns !== 4) begin errors++; $display("FAIL reset_busy_small got %0d expected 4", ns); end
      checks++;
      if ({error, m_arvalid, m_rready} !== 3'b000 || m_arlen !== 8'd15 || m_arsize !== 3'b010 || m_arburst !== 2'b01) begin
         errors++;
         $display("FAIL reset_outputs got err=%b arv=%b rr=%b len=%0d size=%0d burst=%0d", error, m_arvalid, m_rready, m_arlen, m_arsize, m_arburst);
      end
      checks++;
      if ({s_error, s_m_arvalid, s_m_rready} !== 3'b000 || s_m_arlen !== 8'd1 || s_m_arsize !== 3'b010 || s_m_arburst !== 2'b01) begin
         errors++;
         $display("FAIL reset_small_outputs got err=%b arv=%b rr=%b len=%0d", s_error, s_m_arvalid, s_m_rready, s_m_arlen);
      end
      req_valid = 1; s_req_valid = 1;
      for (int i = 0; i < 3; i++) begin
         req_addr = $urandom & 32'hFFFF_FFFC;
         s_req_addr = $urandom & 32'hFFFF_FFFC;
         #1;
         checks++;
         if (hit !== 1'b0 || rdata !== 32'h3F || s_hit !== 1'b0 || s_rdata !== 32'h3F) begin
            errors++;
            $display("FAIL reset_empty got hit=%b rdata=%h s_hit=%b s_rdata=%h expected 0/3f", hit, rdata, s_hit, s_rdata);
         end
      end
      req_valid = 0; s_req_valid = 0;
      @(negedge clk);
   endtask

   task automatic test_fill_hit();
      req_addr = 32'h1044; req_valid = 1;
      #1;
      checks++;
      if (hit !== 1'b0 || rdata !== 32'h3F) begin
         errors++; $display("FAIL miss_1044 got hit=%b rdata=%h expected 0/3f", hit, rdata);
      end
      @(negedge clk);
      req_valid = 0;
      serve_refill(0, -1, 15, -1, 32'h1040);
      req_valid = 1;
      #1;
      checks++;
      if (busy !== 1'b1 || hit !== 1'b0) begin
         errors++; $display("FAIL fill_cycle got busy=%b hit=%b expected 1/0", busy, hit);
      end
      @(negedge clk);
      checks++;
      if (hit !== 1'b1 || rdata !== 32'h1044) begin
         errors++; $display("FAIL refetch_1044 got hit=%b rdata=%h expected 1/00001044", hit, rdata);
      end
      req_addr = 32'h107C;
      #1;
      checks++;
      if (hit !== 1'b1 || rdata !== 32'h107C) begin
         errors++; $display("FAIL hit_107c got hit=%b rdata=%h expected 1/0000107c", hit, rdata);
      end
      req_valid = 0;
      model_fill(32'h1044);
      @(negedge clk);
   endtask

   task automatic test_random();
      int idx_set [4] = '{3, 4, 5, 1023};
      logic [31:0] tag_set [3] = '{32'h0001, 32'h0002, 32'hABCD};
      logic [31:0] pa;
      bit exp;
      for (int it = 0; it < 40; it++) begin
         if ($urandom_range(3) == 0) set_base($urandom & 32'hFFFF_FFFC);
         pa = (tag_set[$urandom_range(2)] << 16) + (32'(idx_set[$urandom_range(3)]) << 6)
              + (32'($urandom_range(15)) << 2);
         exp = model_hit(pa);
         req_addr = pa - model_base; req_valid = 1;
         #1;
         checks++;
         if (hit !== exp || rdata !== (exp ? pa : 32'h3F)) begin
            errors++;
            $display("FAIL rand_lookup pa=%h got hit=%b rdata=%h expected %b/%h", pa, hit, rdata, exp, exp ? pa : 32'h3F);
         end
         if (exp) begin
            req_valid = 0;
            @(negedge clk);
            continue;
         end
         @(negedge clk);
         req_valid = 0;
         serve_refill($urandom_range(0, 3), -1, 15, -1, pa & 32'hFFFF_FFC0);
         @(negedge clk);
         model_fill(pa);
         req_valid = 1;
         #1;
         checks++;
         if (hit !== 1'b1 || rdata !== pa) begin
            errors++; $display("FAIL rand_refetch pa=%h got hit=%b rdata=%h expected 1/%h", pa, hit, rdata, pa);
         end
         req_valid = 0;
         @(negedge clk);
      end
   endtask

   task automatic test_ar_stall();
      set_base(32'h8000_0000);
      req_addr = 32'h10; req_valid = 1;
      #1;
      checks++;
      if (hit !== 1'b0) begin errors++; $display("FAIL stall_miss got hit=%b expected 0", hit); end
      @(negedge clk);
      req_valid = 0;
      mem_start_input = 32'h1234_0000; mem_start_valid = 1;
      serve_refill(7, -1, 15, -1, 32'h8000_0000);
      mem_start_valid = 0;
      model_base = 32'h1234_0000;
      @(negedge clk);
      req_valid = 1;
      #1;
      checks++;
      if (hit !== model_hit(32'h1234_0010)) begin
         errors++; $display("FAIL new_base_lookup got hit=%b expected %b", hit, model_hit(32'h1234_0010));
      end
      req_valid = 0;
      set_base(32'h8000_0000);
      model_fill(32'h8000_0010);
      req_valid = 1;
      #1;
      checks++;
      if (hit !== 1'b1 || rdata !== 32'h8000_0010) begin
         errors++; $display("FAIL stall_refetch got hit=%b rdata=%h expected 1/80000010", hit, rdata);
      end
      req_valid = 0;
      @(negedge clk);
   endtask

   task automatic test_flush();
      logic [31:0] pb = 32'h0055_01C0;
      logic [31:0] pc = 32'h0066_0200;
      int n;
      req_addr = pb - model_base; req_valid = 1;
      @(negedge clk);
      req_valid = 0;
      serve_refill(1, -1, 15, 4, pb);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL flush_fill busy=%b expected 1", busy); end
      n = 0;
      for (int k = 0; k < 1200; k++) begin
         @(negedge clk);
         n++;
         flush = (n == 100);
         if (busy === 1'b0) break;
      end
      flush = 0;
      checks++;
      if (n !== 1025) begin errors++; $display("FAIL pending_flush_clear cycles got %0d expected 1025", n); end
      model_fill(pb);
      model_clear();
      req_addr = pb - model_base; req_valid = 1;
      #1;
      checks++;
      if (hit !== 1'b0) begin errors++; $display("FAIL after_flush_pb got hit=%b expected 0", hit); end
      req_addr = 32'h10;
      #1;
      checks++;
      if (hit !== 1'b0) begin errors++; $display("FAIL after_flush_old got hit=%b expected 0", hit); end
      req_addr = pb - model_base;
      @(negedge clk);
      req_valid = 0;
      serve_refill(0, -1, 15, -1, pb);
      @(negedge clk);
      model_fill(pb);
      req_addr = pb - model_base; req_valid = 1; flush = 1;
      #1;
      checks++;
      if (hit !== 1'b0) begin errors++; $display("FAIL idle_flush_hit got hit=%b expected 0", hit); end
      req_addr = pc - model_base;
      #1;
      checks++;
      if (hit !== 1'b0 || rdata !== 32'h3F) begin
         errors++; $display("FAIL idle_flush_miss got hit=%b rdata=%h expected 0/3f", hit, rdata);
      end
      @(negedge clk);
      flush = 0; req_valid = 0;
      checks++;
      if (busy !== 1'b1 || m_arvalid !== 1'b0) begin
         errors++; $display("FAIL flush_priority got busy=%b arvalid=%b expected 1/0", busy, m_arvalid);
      end
      n = 1;
      for (int k = 0; k < 1200; k++) begin
         if (busy === 1'b0) break;
         @(negedge clk);
         n++;
      end
      checks++;
      if (n !== 1025) begin errors++; $display("FAIL idle_flush_clear cycles got %0d expected 1025", n); end
      model_clear();
      req_addr = pb - model_base; req_valid = 1;
      #1;
      checks++;
      if (hit !== model_hit(pb)) begin errors++; $display("FAIL after_idle_flush got hit=%b expected 0", hit); end
      req_valid = 0;
      @(negedge clk);
   endtask

   task automatic test_err_rlast();
      int nb, ns;
      do_reset(nb, ns);
      req_addr = 32'h2000; req_valid = 1;
      @(negedge clk);
      req_valid = 0;
      serve_refill(0, -1, 3, -1, 32'h2000);
      checks++;
      if (error !== 1'b1 || busy !== 1'b1 || m_rready !== 1'b0 || m_arvalid !== 1'b0) begin
         errors++;
         $display("FAIL early_rlast got err=%b busy=%b rr=%b arv=%b expected 1/1/0/0", error, busy, m_rready, m_arvalid);
      end
   endtask

   task automatic test_err_rresp();
      int nb, ns;
      do_reset(nb, ns);
      checks++;
      if (error !== 1'b0 || nb !== 1024) begin
         errors++; $display("FAIL reset_clears_error got err=%b cycles=%0d expected 0/1024", error, nb);
      end
      req_addr = 32'h1040; req_valid = 1;
      @(negedge clk);
      req_valid = 0;
      serve_refill(0, 5, 15, -1, 32'h1040);
      for (int c = 0; c < 5; c++) begin
         m_arready = 1; m_rvalid = 1; req_valid = 1; req_addr = 32'h1040;
         #1;
         checks++;
         if (hit !== 1'b0 || error !== 1'b1 || busy !== 1'b1 || m_arvalid !== 1'b0 || m_rready !== 1'b0) begin
            errors++;
            $display("FAIL rresp_error c%0d got hit=%b err=%b busy=%b arv=%b rr=%b expected 0/1/1/0/0", c, hit, error, busy, m_arvalid, m_rready);
         end
         @(negedge clk);
      end
      idle_inputs();
   endtask

   initial begin
      resetn = 0;
      idle_inputs();
      model_clear();
      model_base = 0;
      test_reset();
      test_fill_hit();
      test_random();
      test_ar_stall();
      test_flush();
      test_err_rlast();
      test_err_rresp();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog simulation did not complete expected done");
      $fatal(1);
   end

endmodule
